// File: rtl/tbf_pkg.sv
// Shared widths and FSM encoding for the transmit-beamformer channel pulser.
package tbf_pkg;
  localparam int ADDR_WD_DEF = 7;
  localparam int DLY_WD_DEF  = 14;
  localparam int HP_WD_DEF   = 8;
  localparam int NC_WD_DEF   = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    DELAY   = 3'd2,
    PULSE_P = 3'd3,
    PULSE_N = 3'd4,
    DONE    = 3'd5
  } state_t;
endpackage

// File: rtl/tbf_ch_pulser_if.sv
// Control/status bundle between the channel sequencer (master) and the pulser (slave).
// Pure wiring: no latency, no backpressure (fire-and-forget trigger, abort kills).
interface tbf_ch_pulser_if
  import tbf_pkg::*;
#(
  parameter int ADDR_WD = ADDR_WD_DEF,
  parameter int DLY_WD  = DLY_WD_DEF,
  parameter int HP_WD   = HP_WD_DEF,
  parameter int NC_WD   = NC_WD_DEF
) ();
  logic               lut_we;
  logic [ADDR_WD-1:0] lut_addr;
  logic [DLY_WD-1:0]  lut_din;
  logic [ADDR_WD-1:0] line_idx;
  logic               start;
  logic [HP_WD-1:0]   half_period;
  logic [NC_WD-1:0]   num_cycles;
  logic               abort;
  logic               tx_pos;
  logic               tx_neg;
  logic               tx_en;
  logic               tx_done;

  modport master (
    output lut_we, lut_addr, lut_din, line_idx, start, half_period, num_cycles, abort,
    input  tx_pos, tx_neg, tx_en, tx_done
  );

  modport slave (
    input  lut_we, lut_addr, lut_din, line_idx, start, half_period, num_cycles, abort,
    output tx_pos, tx_neg, tx_en, tx_done
  );
endinterface

// File: rtl/tbf_delay_lut.sv
// Per-line transmit delay table, simple dual-port, read-first, one-cycle registered read.
// Writes are always accepted; no backpressure.
module tbf_delay_lut
  import tbf_pkg::*;
#(
  parameter int AW = ADDR_WD_DEF,
  parameter int DW = DLY_WD_DEF
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dat
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rd_dat_q;

  // Both updates are non-blocking, so a same-address write returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_dat;
    if (rd_en) rd_dat_q <= mem_q[rd_addr];
  end

  assign rd_dat = rd_dat_q;
endmodule

// File: rtl/tbf_ch_pulser.sv
// Fires one delayed bipolar burst per start; tx_pos first rises 3+D edges after start.
// No backpressure: start is ignored while busy, abort kills the firing on the next edge.
module tbf_ch_pulser
  import tbf_pkg::*;
#(
  parameter int ADDR_WD = ADDR_WD_DEF,
  parameter int DLY_WD  = DLY_WD_DEF,
  parameter int HP_WD   = HP_WD_DEF,
  parameter int NC_WD   = NC_WD_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  tbf_ch_pulser_if.slave bus
);
  state_t             state_q, state_d;
  logic [DLY_WD-1:0]  dly_cnt_q, dly_cnt_d;
  logic [HP_WD-1:0]   ph_cnt_q, ph_cnt_d;
  logic [NC_WD-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic [HP_WD-1:0]   hp_q, hp_d;
  logic [NC_WD-1:0]   nc_q, nc_d;
  logic               tx_pos_q, tx_pos_d;
  logic               tx_neg_q, tx_neg_d;
  logic               tx_en_q, tx_en_d;
  logic               tx_done_q, tx_done_d;
  logic               start_acc;
  logic               kill;
  logic [DLY_WD-1:0]  lut_rd_dat;

  // tx_en_q still high means the DONE cycle is on the pins; a start there is ignored.
  assign start_acc = (state_q == IDLE) && bus.start && !bus.abort && !tx_en_q;
  assign kill      = bus.abort && (state_q != IDLE);

  // The LUT read register captures the line's delay on the accepting edge,
  // so later writes to that line cannot disturb the firing in progress.
  tbf_delay_lut #(
    .AW (ADDR_WD),
    .DW (DLY_WD)
  ) u_lut (
    .clk     (clk),
    .wr_en   (bus.lut_we),
    .wr_addr (bus.lut_addr),
    .wr_dat  (bus.lut_din),
    .rd_en   (start_acc),
    .rd_addr (bus.line_idx),
    .rd_dat  (lut_rd_dat)
  );

  always_comb begin
    state_d   = state_q;
    dly_cnt_d = dly_cnt_q;
    ph_cnt_d  = ph_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    hp_d      = hp_q;
    nc_d      = nc_q;

    case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d = LOAD;
          hp_d    = (bus.half_period == '0) ? HP_WD'(1) : bus.half_period;
          nc_d    = (bus.num_cycles == '0) ? NC_WD'(1) : bus.num_cycles;
        end
      end
      LOAD: begin
        dly_cnt_d = lut_rd_dat;
        state_d   = DELAY;
      end
      DELAY: begin
        if (dly_cnt_q == '0) begin
          state_d   = PULSE_P;
          ph_cnt_d  = hp_q - HP_WD'(1);
          cyc_cnt_d = nc_q - NC_WD'(1);
        end else begin
          dly_cnt_d = dly_cnt_q - DLY_WD'(1);
        end
      end
      PULSE_P: begin
        if (ph_cnt_q == '0) begin
          state_d  = PULSE_N;
          ph_cnt_d = hp_q - HP_WD'(1);
        end else begin
          ph_cnt_d = ph_cnt_q - HP_WD'(1);
        end
      end
      PULSE_N: begin
        if (ph_cnt_q == '0) begin
          if (cyc_cnt_q == '0) begin
            state_d = DONE;
          end else begin
            state_d   = PULSE_P;
            cyc_cnt_d = cyc_cnt_q - NC_WD'(1);
            ph_cnt_d  = hp_q - HP_WD'(1);
          end
        end else begin
          ph_cnt_d = ph_cnt_q - HP_WD'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (kill) state_d = IDLE;

    // Outputs are the registered image of the current state, blanked by abort.
    tx_pos_d  = (state_q == PULSE_P) && !kill;
    tx_neg_d  = (state_q == PULSE_N) && !kill;
    tx_en_d   = (state_q != IDLE) && !kill;
    tx_done_d = (state_q == DONE) && !kill;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dly_cnt_q <= '0;
      ph_cnt_q  <= '0;
      cyc_cnt_q <= '0;
      hp_q      <= '0;
      nc_q      <= '0;
      tx_pos_q  <= 1'b0;
      tx_neg_q  <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_cnt_q <= dly_cnt_d;
      ph_cnt_q  <= ph_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      hp_q      <= hp_d;
      nc_q      <= nc_d;
      tx_pos_q  <= tx_pos_d;
      tx_neg_q  <= tx_neg_d;
      tx_en_q   <= tx_en_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign bus.tx_pos  = tx_pos_q;
  assign bus.tx_neg  = tx_neg_q;
  assign bus.tx_en   = tx_en_q;
  assign bus.tx_done = tx_done_q;
endmodule

// File: tb/tb_tbf_ch_pulser.sv
// Directed bench for tbf_ch_pulser: timing-formula model compared every cycle plus literal checks.
module tb_tbf_ch_pulser;
  import tbf_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  tbf_ch_pulser_if bus ();

  tbf_ch_pulser dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a firing accepted at edge t0 with delay D, half period hp and nc cycles
  // shows tx_en for r=1..L, pulses for r=3+D..L-1, tx_done at r=L, where L=3+D+2*hp*nc.
  int       lut_m [2**ADDR_WD_DEF];
  int       cyc = 0, t0 = 0, md = 0, mhp = 1, mnc = 1, ml = 0, idle_from = 0;
  int       r_m, ph_m;
  bit       active = 1'b0;
  bit       pulse_m, pos_m;
  logic [3:0] exp_o = 4'b0000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    = 1'b0;
      idle_from = 0;
      exp_o     = 4'b0000;
    end else begin
      cyc++;
      if (active && bus.abort && (cyc - t0) >= 1 && (cyc - t0) <= ml) begin
        active    = 1'b0;
        idle_from = cyc + 1;
      end
      if (bus.start && !bus.abort && cyc >= idle_from) begin
        t0        = cyc;
        md        = lut_m[bus.line_idx];
        mhp       = (bus.half_period == 0) ? 1 : int'(bus.half_period);
        mnc       = (bus.num_cycles == 0) ? 1 : int'(bus.num_cycles);
        ml        = 3 + md + 2 * mhp * mnc;
        idle_from = t0 + ml + 2;
        active    = 1'b1;
      end
      if (bus.lut_we) lut_m[bus.lut_addr] = int'(bus.lut_din);
      exp_o = 4'b0000;
      if (active) begin
        r_m     = cyc - t0;
        ph_m    = r_m - 3 - md;
        pulse_m = (r_m >= 3 + md) && (r_m < ml);
        pos_m   = pulse_m && ((ph_m % (2 * mhp)) < mhp);
        exp_o   = {pos_m, pulse_m && !pos_m, (r_m >= 1) && (r_m <= ml), r_m == ml};
      end
    end
  end

  always @(negedge clk) begin
    chk("outputs{pos,neg,en,done}", int'({bus.tx_pos, bus.tx_neg, bus.tx_en, bus.tx_done}),
        int'(exp_o));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lut_wr(input int a, input int d);
    bus.lut_we   = 1'b1;
    bus.lut_addr = a[ADDR_WD_DEF-1:0];
    bus.lut_din  = d[DLY_WD_DEF-1:0];
    tick();
    bus.lut_we = 1'b0;
  endtask

  // Drives start for exactly one edge (E0) and returns just after it.
  task automatic launch(input int idx, input int hp, input int nc);
    bus.line_idx    = idx[ADDR_WD_DEF-1:0];
    bus.half_period = hp[HP_WD_DEF-1:0];
    bus.num_cycles  = nc[NC_WD_DEF-1:0];
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic fire(input int idx, input int hp, input int nc,
                      input bit wr_in_load, input int wr_dat,
                      output int rise, output int en_n, output int pos_n,
                      output int neg_n, output int done_n);
    bit ended;
    launch(idx, hp, nc);
    if (wr_in_load) begin
      bus.lut_we   = 1'b1;
      bus.lut_addr = idx[ADDR_WD_DEF-1:0];
      bus.lut_din  = wr_dat[DLY_WD_DEF-1:0];
    end
    rise = -1; en_n = 0; pos_n = 0; neg_n = 0; done_n = 0; ended = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      tick();
      bus.lut_we = 1'b0;
      if (bus.tx_pos && rise < 0) rise = n;
      en_n   += int'(bus.tx_en);
      pos_n  += int'(bus.tx_pos);
      neg_n  += int'(bus.tx_neg);
      done_n += int'(bus.tx_done);
      if (n > 1 && !bus.tx_en) begin
        ended = 1'b1;
        break;
      end
    end
    chk("fire_terminates", int'(ended), 1);
  endtask

  int rise, en_n, pos_n, neg_n, done_n;
  int en_hist [70];

  initial begin
    bus.lut_we = 1'b0; bus.lut_addr = '0; bus.lut_din = '0;
    bus.line_idx = '0; bus.start = 1'b0; bus.half_period = '0;
    bus.num_cycles = '0; bus.abort = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("reset_state", int'({bus.tx_pos, bus.tx_neg, bus.tx_en, bus.tx_done}), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    lut_wr(5, 10);
    lut_wr(0, 0);
    lut_wr(3, 7);

    // Line 5, D=10, 4P/4N x2.
    fire(5, 4, 2, 1'b0, 0, rise, en_n, pos_n, neg_n, done_n);
    chk("d10_rise", rise, 13);
    chk("d10_en_cycles", en_n, 29);
    chk("d10_pos_cycles", pos_n, 8);
    chk("d10_neg_cycles", neg_n, 8);
    chk("d10_done", done_n, 1);

    // Zero half_period / num_cycles behave as 1.
    fire(0, 0, 0, 1'b0, 0, rise, en_n, pos_n, neg_n, done_n);
    chk("d0_rise", rise, 3);
    chk("d0_en_cycles", en_n, 5);
    chk("d0_pos_cycles", pos_n, 1);
    chk("d0_neg_cycles", neg_n, 1);

    fire(3, 2, 3, 1'b0, 0, rise, en_n, pos_n, neg_n, done_n);
    chk("d7_rise", rise, 10);
    chk("d7_en_cycles", en_n, 22);
    chk("d7_pos_cycles", pos_n, 6);

    // Abort in DELAY.
    launch(5, 4, 2);
    repeat (5) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_delay_en", int'(bus.tx_en), 0);
    done_n = 0; pos_n = 0;
    repeat (30) begin
      tick();
      done_n += int'(bus.tx_done);
      pos_n  += int'(bus.tx_pos);
    end
    chk("abort_delay_no_done", done_n, 0);
    chk("abort_delay_no_pos", pos_n, 0);
    fire(5, 4, 2, 1'b0, 0, rise, en_n, pos_n, neg_n, done_n);
    chk("after_abort_rise", rise, 13);

    // Abort in PULSE_N, then restart on the very next edge.
    launch(0, 4, 2);
    repeat (7) tick();
    chk("pulse_n_reached", int'(bus.tx_neg), 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_pn_outputs", int'({bus.tx_pos, bus.tx_neg, bus.tx_en, bus.tx_done}), 0);
    fire(0, 1, 1, 1'b0, 0, rise, en_n, pos_n, neg_n, done_n);
    chk("after_abort_pn_rise", rise, 3);
    chk("after_abort_pn_done", done_n, 1);

    // start held high: one burst, next firing only after the pulser is idle again.
    bus.line_idx = 7'd5; bus.half_period = 8'd4; bus.num_cycles = 4'd2;
    bus.start = 1'b1;
    done_n = 0;
    for (int n = 0; n < 70; n++) begin
      tick();
      if (n == 39) bus.start = 1'b0;
      en_hist[n] = int'(bus.tx_en);
      done_n += int'(bus.tx_done);
    end
    en_n = 0;
    for (int n = 1; n <= 29; n++) en_n += en_hist[n];
    chk("hold_first_en", en_n, 29);
    chk("hold_gap", en_hist[30] + en_hist[31], 0);
    chk("hold_second_start", en_hist[32], 1);
    chk("hold_done_count", done_n, 2);
    repeat (5) tick();

    // LUT write during LOAD affects only the next firing.
    fire(5, 4, 2, 1'b1, 20, rise, en_n, pos_n, neg_n, done_n);
    chk("wr_in_load_rise", rise, 13);
    fire(5, 4, 2, 1'b0, 0, rise, en_n, pos_n, neg_n, done_n);
    chk("next_uses_new_rise", rise, 23);
    chk("next_uses_new_en", en_n, 39);
    lut_wr(5, 10);

    // Asynchronous reset in PULSE_P; LUT survives.
    launch(5, 4, 2);
    repeat (14) tick();
    chk("pulse_p_reached", int'(bus.tx_pos), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", int'({bus.tx_pos, bus.tx_neg, bus.tx_en, bus.tx_done}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fire(5, 4, 2, 1'b0, 0, rise, en_n, pos_n, neg_n, done_n);
    chk("post_reset_rise", rise, 13);
    chk("post_reset_en", en_n, 29);
    chk("post_reset_done", done_n, 1);

    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
